// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants and types for the architectural register file.
`default_nettype none

package regfile_pkg;

  localparam int WIDTH    = 64;
  localparam int NREGS    = 32;
  localparam int ADDR_W   = $clog2(NREGS);
  localparam int ZERO_REG = 31;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/regfile_entry.sv
// regfile_entry: one register word with write enable and asynchronous active-low clear.
`default_nettype none

module regfile_entry #(
  parameter int WIDTH = regfile_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_bypass.sv
// reg_file_bypass: 2R/1W register file with same-cycle write forwarding and a
// per-register pending scoreboard; the ZERO_REG index reads zero and is never pending.
`default_nettype none

module reg_file_bypass #(
  parameter int WIDTH    = regfile_pkg::WIDTH,
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rd_addr1,
  input  logic [$clog2(NREGS)-1:0] rd_addr2,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [WIDTH-1:0]         rd_data2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     iss_en,
  input  logic [$clog2(NREGS)-1:0] iss_addr
);

  import regfile_pkg::*;

  localparam int             AW    = $clog2(NREGS);
  localparam logic [AW-1:0]  ZADDR = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  // An address names real storage only if it is in range and not the zero register.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a != ZADDR) && ({{(32-AW){1'b0}}, a} < 32'(NREGS));
  endfunction

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_regs
      if (i == ZERO_REG) begin : g_zero
        assign regs[i] = '0;
      end else begin : g_word
        regfile_entry #(.WIDTH(WIDTH)) u_entry (
          .clk   (clk),
          .reset (reset),
          .we    (wr_en && (wr_addr == AW'(i))),
          .d     (wr_data),
          .q     (regs[i])
        );
      end
    end
  endgenerate

  logic hit1, hit2, ok1, ok2;
  assign ok1  = addr_valid(rd_addr1);
  assign ok2  = addr_valid(rd_addr2);
  assign hit1 = wr_en && (wr_addr == rd_addr1);
  assign hit2 = wr_en && (wr_addr == rd_addr2);

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (ok1) rd_data1 = hit1 ? wr_data : regs[rd_addr1];
    if (ok2) rd_data2 = hit2 ? wr_data : regs[rd_addr2];
  end

  assign busy1 = ok1 && pending[rd_addr1] && !hit1;
  assign busy2 = ok2 && pending[rd_addr2] && !hit2;

  // Issue is applied after writeback so a newer producer keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (wr_en && addr_valid(wr_addr)) pending_nxt[wr_addr] = 1'b0;
    if (iss_en && addr_valid(iss_addr)) pending_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_bypass.sv
// tb_reg_file_bypass: directed plus randomized checks against an array-based model.
`default_nettype none

module tb_reg_file_bypass;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  reg_addr_t rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, iss_addr = '0;
  word_t     rd_data1, rd_data2, wr_data = '0;
  logic      busy1, busy2;
  logic      wr_en = 1'b0, iss_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  word_t m_regs [NREGS];
  bit    m_pend [NREGS];

  reg_file_bypass dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .busy1(busy1), .busy2(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NREGS; k++) begin
      m_regs[k] = '0;
      m_pend[k] = 1'b0;
    end
  endtask

  // Register state change at a clock edge; issue processed last so it wins.
  task automatic model_update();
    if (wr_en && wr_addr != reg_addr_t'(ZERO_REG)) begin
      m_regs[wr_addr] = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (iss_en && iss_addr != reg_addr_t'(ZERO_REG)) m_pend[iss_addr] = 1'b1;
  endtask

  function automatic word_t exp_data(input reg_addr_t a);
    if (a == reg_addr_t'(ZERO_REG)) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic word_t exp_busy(input reg_addr_t a);
    if (a == reg_addr_t'(ZERO_REG)) return '0;
    return word_t'(m_pend[a] && !(wr_en && wr_addr == a));
  endfunction

  task automatic compare();
    chk("rd_data1", rd_data1, exp_data(rd_addr1));
    chk("rd_data2", rd_data2, exp_data(rd_addr2));
    chk("busy1", word_t'(busy1), exp_busy(rd_addr1));
    chk("busy2", word_t'(busy2), exp_busy(rd_addr2));
  endtask

  // Called at a negedge: apply inputs, settle, compare against the model.
  task automatic drive(input bit rst, input reg_addr_t a1, input reg_addr_t a2,
                       input bit we, input reg_addr_t wa, input word_t wd,
                       input bit ie, input reg_addr_t ia);
    reset = rst; rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    #1;
    if (!reset) model_clear();
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_update();
    @(negedge clk);
  endtask

  function automatic reg_addr_t rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? reg_addr_t'(ZERO_REG) : reg_addr_t'(r);
  endfunction

  initial begin
    model_clear();
    @(negedge clk);

    // Reset held with random addresses and random issues
    for (int c = 0; c < 4; c++) begin
      drive(0, rnd_addr(), rnd_addr(), 0, rnd_addr(), 64'(c), 1, rnd_addr());
      chk("rst_rd1", rd_data1, '0);
      chk("rst_busy2", word_t'(busy2), '0);
      tick();
    end

    drive(1, 5'd0, 5'd30, 0, 5'd0, '0, 0, 5'd0);
    chk("x0_after_reset", rd_data1, '0);
    chk("x30_after_reset", rd_data2, '0);
    tick();

    // Write then read X5 on both ports
    drive(1, 5'd1, 5'd2, 1, 5'd5, 64'hDEAD_BEEF_0000_0001, 0, 5'd0);
    tick();
    drive(1, 5'd5, 5'd5, 0, 5'd0, '0, 0, 5'd0);
    chk("x5_p1", rd_data1, 64'hDEAD_BEEF_0000_0001);
    chk("x5_p2", rd_data2, 64'hDEAD_BEEF_0000_0001);
    tick();

    // Same-cycle bypass
    drive(1, 5'd7, 5'd0, 1, 5'd7, 64'h1234, 0, 5'd0);
    chk("bypass_x7", rd_data1, 64'h1234);
    tick();

    // Zero register: writes dropped, never pending
    drive(1, 5'd31, 5'd31, 1, 5'd31, 64'hFFFF, 1, 5'd31);
    chk("xzr_wr_same", rd_data1, '0);
    tick();
    drive(1, 5'd31, 5'd31, 0, 5'd0, '0, 0, 5'd0);
    chk("xzr_rd", rd_data2, '0);
    chk("xzr_busy", word_t'(busy1), '0);
    tick();

    // Scoreboard on X3
    drive(1, 5'd0, 5'd0, 0, 5'd0, '0, 1, 5'd3);
    tick();
    drive(1, 5'd0, 5'd3, 0, 5'd0, '0, 0, 5'd0);
    chk("x3_busy_after_iss", word_t'(busy2), 64'd1);
    tick();
    drive(1, 5'd0, 5'd3, 1, 5'd3, 64'hABCD, 0, 5'd0);
    chk("x3_wb_busy", word_t'(busy2), '0);
    chk("x3_wb_data", rd_data2, 64'hABCD);
    tick();
    drive(1, 5'd0, 5'd3, 1, 5'd3, 64'h77, 1, 5'd3);
    chk("x3_simul_busy", word_t'(busy2), '0);
    tick();
    drive(1, 5'd0, 5'd3, 0, 5'd0, '0, 0, 5'd0);
    chk("x3_set_wins", word_t'(busy2), 64'd1);
    chk("x3_value", rd_data2, 64'h77);
    tick();

    // Asynchronous reset between edges
    drive(1, 5'd0, 5'd0, 1, 5'd9, 64'h55, 1, 5'd9);
    tick();
    drive(1, 5'd9, 5'd9, 0, 5'd0, '0, 0, 5'd0);
    chk("x9_pre_val", rd_data1, 64'h55);
    chk("x9_pre_busy", word_t'(busy1), 64'd1);
    #1 reset = 1'b0;
    #1;
    model_clear();
    chk("x9_async_val", rd_data1, '0);
    chk("x9_async_busy", word_t'(busy1), '0);
    compare();
    #1 reset = 1'b1;
    tick();

    // Randomized traffic with occasional reset cycles
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0), rnd_addr(), rnd_addr(),
            $urandom_range(0, 1), rnd_addr(), {$urandom, $urandom},
            $urandom_range(0, 1), rnd_addr());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
